// File: rtl/tile_draw_pkg.sv
// Shared constants and types for the tile picture pixel pipeline.
package tile_draw_pkg;

  localparam int unsigned TILE_PX    = 16;
  localparam int unsigned MAP_DIM    = 8;
  localparam int unsigned PIC_PX     = 128;
  localparam int unsigned MAP_ADDR_W = 6;
  localparam int unsigned ROM_ADDR_W = 14;

  typedef logic [5:0] tile_id_t;
  typedef logic [4:0] pal_idx_t;
  typedef logic [6:0] wr_addr_t;

  localparam wr_addr_t SCROLL_X_ADDR = 7'd64;
  localparam wr_addr_t SCROLL_Y_ADDR = 7'd65;

  // Tile-map entry covering picture coordinate (px, py): row-major, 8 tiles per row.
  function automatic logic [MAP_ADDR_W-1:0] map_index(input logic [6:0] px,
                                                      input logic [6:0] py);
    return {py[6:4], px[6:4]};
  endfunction

endpackage

// File: rtl/tile_draw_ctrl_tile_map_ram.sv
// 64x6 simple dual-port tile map, synchronous read, read-before-write on collisions.
module tile_draw_ctrl_tile_map_ram
  import tile_draw_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [MAP_ADDR_W-1:0] i_wr_addr,
  input  logic [5:0]            i_wr_data,
  input  logic [MAP_ADDR_W-1:0] i_rd_addr,
  output logic [5:0]            o_rd_data
);

  localparam int unsigned Depth = MAP_DIM * MAP_DIM;

  tile_id_t r_mem [Depth];
  tile_id_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tile_draw_ctrl.sv
// Pixel pipeline: screen position -> tile map -> tile ROM -> palette index.
// Optional scroll registers are built when TILE_DRAW_SCROLL_EN is defined.
module tile_draw_ctrl
  import tile_draw_pkg::*;
#(
  parameter int unsigned ORIGIN_X = 256,
  parameter int unsigned ORIGIN_Y = 176
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [9:0]            i_draw_x,
  input  logic [9:0]            i_draw_y,
  input  logic                  i_blank,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [6:0]            i_wr_addr,
  input  logic [6:0]            i_wr_data,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [4:0]            i_rom_data,
  output logic [4:0]            o_pal_index,
  output logic                  o_pal_valid
);

  localparam int unsigned SubW = $clog2(TILE_PX);
  localparam logic [9:0]  OrgX = 10'(ORIGIN_X);
  localparam logic [9:0]  OrgY = 10'(ORIGIN_Y);
  localparam logic [9:0]  EndX = 10'(ORIGIN_X + PIC_PX);
  localparam logic [9:0]  EndY = 10'(ORIGIN_Y + PIC_PX);

  logic            w_wr_fire;
  logic            w_map_we;
  logic [6:0]      w_scroll_x;
  logic [6:0]      w_scroll_y;
  logic [6:0]      w_rel_x;
  logic [6:0]      w_rel_y;
  logic [6:0]      w_px;
  logic [6:0]      w_py;
  logic            w_in_region;
  tile_id_t        w_tile_id;

  logic [SubW-1:0]       r_s0_px;
  logic [SubW-1:0]       r_s0_py;
  logic                  r_s0_in;
  logic                  r_s0_live;
  logic                  r_s1_in;
  logic                  r_s2_in;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  pal_idx_t              r_pal_index;
  logic                  r_pal_valid;

  assign o_wr_ready = i_blank & i_reset_n;
  assign w_wr_fire  = i_wr_valid & o_wr_ready;
  assign w_map_we   = w_wr_fire & ~i_wr_addr[6];

`ifdef TILE_DRAW_SCROLL_EN
  logic [6:0] r_scroll_x;
  logic [6:0] r_scroll_y;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_scroll_x <= '0;
      r_scroll_y <= '0;
    end else if (w_wr_fire) begin
      if (i_wr_addr == SCROLL_X_ADDR) r_scroll_x <= i_wr_data;
      if (i_wr_addr == SCROLL_Y_ADDR) r_scroll_y <= i_wr_data;
    end
  end

  assign w_scroll_x = r_scroll_x;
  assign w_scroll_y = r_scroll_y;
`else
  logic w_unused_wr_data;

  assign w_scroll_x       = '0;
  assign w_scroll_y       = '0;
  assign w_unused_wr_data = i_wr_data[6];
`endif

  // Low 7 bits of the offset only depend on the low 7 bits of the operands.
  assign w_rel_x = i_draw_x[6:0] - OrgX[6:0];
  assign w_rel_y = i_draw_y[6:0] - OrgY[6:0];
  assign w_px    = w_rel_x + w_scroll_x;
  assign w_py    = w_rel_y + w_scroll_y;

  assign w_in_region = ~i_blank
                     & (i_draw_x >= OrgX) & (i_draw_x < EndX)
                     & (i_draw_y >= OrgY) & (i_draw_y < EndY);

  tile_draw_ctrl_tile_map_ram u_map (
    .i_clk     (i_clk),
    .i_wr_en   (w_map_we),
    .i_wr_addr (i_wr_addr[5:0]),
    .i_wr_data (i_wr_data[5:0]),
    .i_rd_addr (map_index(w_px, w_py)),
    .o_rd_data (w_tile_id)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s0_px     <= '0;
      r_s0_py     <= '0;
      r_s0_in     <= 1'b0;
      r_s0_live   <= 1'b0;
      r_s1_in     <= 1'b0;
      r_s2_in     <= 1'b0;
      r_rom_addr  <= '0;
      r_pal_index <= '0;
      r_pal_valid <= 1'b0;
    end else begin
      r_s0_px   <= w_px[SubW-1:0];
      r_s0_py   <= w_py[SubW-1:0];
      r_s0_in   <= w_in_region;
      r_s0_live <= 1'b1;
      // Hold the reset address until a real post-reset sample reaches stage 1.
      if (r_s0_live) begin
        r_rom_addr <= {w_tile_id, r_s0_py, r_s0_px};
      end
      r_s1_in     <= r_s0_in;
      r_s2_in     <= r_s1_in;
      r_pal_valid <= r_s2_in;
      r_pal_index <= r_s2_in ? i_rom_data : '0;
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_pal_index = r_pal_index;
  assign o_pal_valid = r_pal_valid;

endmodule

// File: tb/tb_tile_draw_ctrl.sv
// Self-checking bench: per-cycle reference model plus directed literal checks.
module tb_tile_draw_ctrl;

  localparam int OX = 256;
  localparam int OY = 176;
`ifdef TILE_DRAW_SCROLL_EN
  localparam int ScrollPx = 2;
`else
  localparam int ScrollPx = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic        blank = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [6:0]  wr_addr = '0;
  logic [6:0]  wr_data = '0;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic [4:0]  pal_index;
  logic        pal_valid;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;

  tile_draw_ctrl #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_draw_x    (draw_x),
    .i_draw_y    (draw_y),
    .i_blank     (blank),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_pal_index (pal_index),
    .o_pal_valid (pal_valid)
  );

  always #5 clk = ~clk;

  // Tile ROM stand-in: returns the low 5 address bits one cycle later.
  always @(posedge clk) rom_data <= rom_addr[4:0];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each sampled pixel becomes a record; outputs are read off
  // the record sampled 1 edge ago (rom_addr) and 3 edges ago (palette).
  typedef struct {
    bit inreg;
    bit known;
    int addr;
  } pix_t;

  pix_t q[$];
  pix_t m_p;
  int   mmap[64];
  bit   mknown[64];
  int   sx = 0;
  int   sy = 0;
  int   m_rx, m_ry, m_px, m_py, m_idx;

  initial begin : compare
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        q.delete();
        sx = 0;
        sy = 0;
      end else begin
        m_rx = int'(draw_x) - OX;
        m_ry = int'(draw_y) - OY;
        m_p.inreg = !blank && m_rx >= 0 && m_rx < 128 && m_ry >= 0 && m_ry < 128;
        m_px = ((m_rx & 127) + sx) % 128;
        m_py = ((m_ry & 127) + sy) % 128;
        m_idx = (m_py / 16) * 8 + m_px / 16;
        m_p.known = mknown[m_idx];
        m_p.addr = mmap[m_idx] * 256 + (m_py % 16) * 16 + (m_px % 16);
        q.push_front(m_p);
        if (q.size() > 4) void'(q.pop_back());
        if (wr_valid && blank) begin
          if (wr_addr < 7'd64) begin
            mmap[wr_addr] = int'(wr_data) & 63;
            mknown[wr_addr] = 1'b1;
          end
`ifdef TILE_DRAW_SCROLL_EN
          else if (wr_addr == 7'd64) sx = int'(wr_data);
          else if (wr_addr == 7'd65) sy = int'(wr_data);
`endif
        end
      end
      #1;
      chk("model_wr_ready", int'(wr_ready), int'(blank && reset_n));
      if (q.size() >= 2) begin
        if (q[1].known) chk("model_rom_addr", int'(rom_addr), q[1].addr);
      end else begin
        chk("model_rom_addr_idle", int'(rom_addr), 0);
      end
      if (q.size() >= 4) begin
        chk("model_pal_valid", int'(pal_valid), int'(q[3].inreg));
        if (q[3].known || !q[3].inreg)
          chk("model_pal_index", int'(pal_index), q[3].inreg ? (q[3].addr & 31) : 0);
      end else begin
        chk("model_pal_valid_idle", int'(pal_valid), 0);
        chk("model_pal_index_idle", int'(pal_index), 0);
      end
      if (pal_valid) valid_cnt++;
    end
  end

  task automatic step(input int x, input int y, input bit b);
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = b;
  endtask

  task automatic idle(input int n);
    step(0, 0, 1'b1);
    repeat (n) @(posedge clk);
  endtask

  task automatic host_write(input int a, input int d);
    @(negedge clk);
    blank    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 7'(a);
    wr_data  = 7'(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // One pixel, then blank; palette output checked exactly 3 edges after its sample.
  task automatic probe(input int x, input int y, input int ev, input int ei);
    idle(4);
    step(x, y, 1'b0);
    step(0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk($sformatf("probe_valid_x%0d_y%0d", x, y), int'(pal_valid), ev);
    chk($sformatf("probe_index_x%0d_y%0d", x, y), int'(pal_index), ei);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pal_valid", int'(pal_valid), 0);
    chk("reset_pal_index", int'(pal_index), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 64; i++) host_write(i, (i * 5 + 3) & 63);

    // map[9] = 5, then pixel (272,192) lies in tile (1,1)
    host_write(9, 5);
    step(272, 192, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("map9_rom_addr", int'(rom_addr), 14'h500);

    idle(5);
    valid_cnt = 0;
    for (int x = 250; x <= 400; x++) step(x, 176, 1'b0);
    idle(5);
    chk("sweep_valid_count", valid_cnt, 128);

    probe(255, 176, 0, 0);
    probe(256, 176, 1, 0);
    probe(383, 176, 1, 15);
    probe(384, 176, 0, 0);
    probe(260, 177, 1, 20);
    probe(300, 175, 0, 0);

    // Write to map[10] held through 20 active cycles; tile 10 still reads old id 53.
    idle(4);
    step(288, 192, 1'b0);
    wr_valid = 1'b1;
    wr_addr  = 7'd10;
    wr_data  = 7'd33;
    repeat (20) begin
      @(posedge clk);
      #2;
      chk("stall_wr_ready", int'(wr_ready), 0);
    end
    chk("stall_old_tile", int'(rom_addr), 53 * 256);
    @(negedge clk);
    blank = 1'b1;
    @(posedge clk);
    #2;
    chk("stall_accept_ready", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    blank    = 1'b0;
    @(posedge clk);
    #2;
    chk("stall_inflight_old", int'(rom_addr), 53 * 256);
    @(posedge clk);
    #2;
    chk("stall_new_tile", int'(rom_addr), 33 * 256);

    // Same-edge read and write of map[0]: old id 3, new id 7.
    idle(4);
    step(256, 176, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = 7'd0;
    wr_data  = 7'd7;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    blank    = 1'b0;
    @(posedge clk);
    #2;
    chk("collide_old_id", int'(rom_addr), 3 * 256);
    @(posedge clk);
    #2;
    chk("collide_new_id", int'(rom_addr), 7 * 256);

    host_write(100, 21);

    // scroll_x = 120: rel 10 wraps to px 2 when scrolling is built in.
    host_write(64, 120);
    step(266, 176, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("scroll_rom_addr", int'(rom_addr), 7 * 256 + ScrollPx);

    // Reset mid-line at x=300 with the pipeline full of visible pixels.
    idle(4);
    for (int x = 290; x <= 300; x++) step(x, 176, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("prereset_pal_valid", int'(pal_valid), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_pal_valid", int'(pal_valid), 0);
    chk("midreset_pal_index", int'(pal_index), 0);
    chk("midreset_rom_addr", int'(rom_addr), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    draw_x  = 10'd266;
    draw_y  = 10'd176;
    blank   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("postreset_rom_addr", int'(rom_addr), 7 * 256 + 10);
    chk("postreset_valid_n1", int'(pal_valid), 0);
    @(posedge clk);
    #2;
    chk("postreset_valid_n2", int'(pal_valid), 0);
    @(posedge clk);
    #2;
    chk("postreset_valid_n3", int'(pal_valid), 1);
    chk("postreset_index_n3", int'(pal_index), 10);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_draw_ctrl.md
# tile_draw_ctrl

Pixel-pipeline sequencer for the 64-tile picture. It sits between the VGA timing generator and the tile palette. For each screen pixel it translates draw_x/draw_y into an 8x8 tile-map lookup and then a tile-pixel ROM fetch, and it emits the 5-bit palette index consumed by the palette. It also owns the tile map and arbitrates host writes into it, accepting them only during blanking.

## Interface
- ORIGIN_X, default 256: screen x of the picture's left edge.
- ORIGIN_Y, default 176: screen y of the picture's top edge.
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- draw_x  in  10  current pixel column from the VGA generator
- draw_y  in  10  current pixel row from the VGA generator
- blank  in  1  1 = outside the visible area
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle when high together with wr_valid
- wr_addr  in  7  0–63 = map entry (row*8+col); 64 = scroll_x; 65 = scroll_y
- wr_data  in  7  tile id in bits [5:0] for map writes, 7-bit value for scroll writes
- rom_addr  out  14  tile ROM address {tile_id[5:0], py[3:0], px[3:0]}
- rom_data  in  5  palette index returned by the ROM; 1-cycle synchronous latency
- pal_index  out  5  index to the palette
- pal_valid  out  1  pixel lies inside the 128x128 picture

## Operation
- Picture geometry: 8x8 tiles, each 16x16 pixels, 128x128 pixels total.
- Stage 0 (edge N): compute rel_x = draw_x − ORIGIN_X and rel_y = draw_y − ORIGIN_Y.
  - in_region = !blank && 0 ≤ rel_x < 128 && 0 ≤ rel_y < 128, evaluated with 10-bit unsigned compares against ORIGIN and ORIGIN+128.
  - px = (rel_x[6:0] + scroll_x) mod 128; py = (rel_y[6:0] + scroll_y) mod 128. Both are 7-bit wrapping adds.
  - Present map read address {py[6:4], px[6:4]}.
  - Register px[3:0], py[3:0] and in_region.
- Stage 1 (edge N+1): register rom_addr = {tile_id, py[3:0], px[3:0]} and the delayed in_region.
- Stage 2 (edge N+2): ROM samples rom_addr; in_region is delayed again.
- Stage 3 (edge N+3): pal_index = in_region ? rom_data : 0; pal_valid = in_region.
- Tile map: 64x6 simple dual-port RAM with synchronous read.
  - Contents initialise to 0 at configuration; reset_n does not clear them.
- Write arbitration: wr_ready = blank && reset_n is deasserted, combinational.
  - A write is accepted on an edge where wr_valid && wr_ready.
  - While blank = 0, requests stall; the host must hold wr_valid, wr_addr and wr_data stable until accepted.
  - Accepted addresses 66–127 complete the handshake but have no effect.
  - Map read and map write to the same entry on the same edge: the read returns the old data.
- Scroll registers are written only on accepted writes. New values take effect for pixels sampled on the following edge.

## Timing
- Latency: draw_x/draw_y sampled at edge N → rom_addr valid after N+1 → pal_index/pal_valid valid after N+3.
- Fully pipelined: one pixel per clock, no bubbles.
- Reset values: pal_index = 0, pal_valid = 0, rom_addr = 0, scroll_x = 0, scroll_y = 0, all pipeline valid bits = 0, wr_ready = 0.
- Reset asserted mid-line flushes the pipeline. The first valid pixel appears 3 edges after the first post-reset sample.
- blank rising mid-pipeline: pixels already in flight complete with their sampled in_region. Writes accepted in that window do not affect pixels already in flight.
- Boundaries:
  - draw_x = ORIGIN_X + 127 → pal_valid = 1; draw_x = ORIGIN_X + 128 → pal_valid = 0.
  - draw_x < ORIGIN_X must not wrap into the region; this is guaranteed by the unsigned compare.

## Configuration
- TILE_DRAW_SCROLL_EN defined: scroll_x and scroll_y registers exist and are writable at addresses 64 and 65.
- Undefined:
  - Scroll is constant 0.
  - Addresses 64–127 are accepted and ignored.
  - No scroll flops are synthesised.
- Pipeline latency is identical in both builds.

## Structure
- tile_draw_pkg holds:
  - constants TILE_PX = 16, MAP_DIM = 8, PIC_PX = 128, MAP_ADDR_W = 6, ROM_ADDR_W = 14;
  - types tile_id_t (6 b), pal_idx_t (5 b), wr_addr_t (7 b);
  - address constants SCROLL_X_ADDR = 64, SCROLL_Y_ADDR = 65.
- One sub-module: tile_map_ram, a 64x6 simple dual-port RAM with synchronous read that infers block RAM.

## Test plan
- Reset, then sweep draw_x 250–400 on draw_y = 176 with ROM model = low 5 bits of address:
  - pal_valid high exactly for samples of draw_x 256–383, 3 cycles later;
  - pal_index = px[3:0] pattern.
- Write map[9] = 6'd5 during blank, then draw (x=272, y=192) → rom_addr = {6'd5, 4'd0, 4'd0} after 1 edge.
- Assert wr_valid with blank = 0 for 20 cycles, then raise blank:
  - wr_ready = 0 throughout the active period;
  - the write lands on the first blank edge, and exactly once.
- TILE_DRAW_SCROLL_EN: write scroll_x = 120, then draw x = 266 (rel 10) → px = 2, map column 0 (wraps from 130).
- Assert reset_n low mid-line at pixel x = 300 → pal_valid/pal_index go to 0 immediately; rom_addr = 0; scroll = 0; map contents retained.
- Same-edge read and write of map[0] (new id 7) at the blank boundary → the in-flight pixel uses the old id, and the next line uses 7.
